// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED pattern controller.
package led_pkg;

  localparam int unsigned MODE_W   = 2;
  localparam int unsigned CH_IDX_W = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } led_mode_e;

  // LED level a channel takes on the edge it is (re)configured into a mode.
  function automatic logic mode_led_init(input led_mode_e mode);
    return (mode == MODE_ON) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler; tick is high for the single cycle in which the count is TICK_DIV-1.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= tick_d;
    end
  end

  // tick is registered from the next count so it lines up with cnt_q == CNT_LAST.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == CNT_LAST);
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED pattern controller: shared tick, per-channel OFF/ON/BLINK/ONESHOT engines.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CH_NUM         = 4,
  parameter int unsigned TICK_DIV       = 50_000,
  parameter int unsigned PERIOD_W       = 16,
  parameter int unsigned DEFAULT_PERIOD = 500
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cfg_valid,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                cfg_ack,
  output logic                cfg_err,
  output logic [CH_NUM-1:0]   led_out,
  output logic [CH_NUM-1:0]   done
);

  localparam logic [CH_IDX_W:0]   CH_LIMIT   = (CH_IDX_W + 1)'(CH_NUM);
  localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(DEFAULT_PERIOD);

  logic                tick;
  logic                cfg_accept;
  logic                cfg_reject;
  logic [PERIOD_W-1:0] cfg_period_fix;
  led_mode_e           cfg_mode_e;
  logic                ack_pend_q;
  logic                err_pend_q;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick)
  );

  assign cfg_accept     = cfg_valid && ({1'b0, cfg_ch} < CH_LIMIT);
  assign cfg_reject     = cfg_valid && !({1'b0, cfg_ch} < CH_LIMIT);
  assign cfg_period_fix = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
  assign cfg_mode_e     = led_mode_e'(cfg_mode);

  // Write status reaches the port one cycle after the channel registers update.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      cfg_ack    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      ack_pend_q <= cfg_accept;
      err_pend_q <= cfg_reject;
      cfg_ack    <= ack_pend_q;
      cfg_err    <= err_pend_q;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    led_mode_e           mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                led_q, led_d;
    logic                done_q, done_d;
    logic                wr;
    logic                cnt_last;

    assign wr       = cfg_accept && (cfg_ch == CH_IDX_W'(g));
    assign cnt_last = (cnt_q == (period_q - PERIOD_W'(1)));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        mode_q   <= MODE_BLINK;
        period_q <= PERIOD_RST;
        cnt_q    <= '0;
        led_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        period_q <= period_d;
        cnt_q    <= cnt_d;
        led_q    <= led_d;
        done_q   <= done_d;
      end
    end

    // A write on this channel overrides any tick in the same cycle.
    always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      led_d    = led_q;
      done_d   = 1'b0;
      if (wr) begin
        mode_d   = cfg_mode_e;
        period_d = cfg_period_fix;
        cnt_d    = '0;
        led_d    = mode_led_init(cfg_mode_e);
      end else begin
        unique case (mode_q)
          MODE_OFF: begin
            led_d = 1'b0;
            cnt_d = '0;
          end
          MODE_ON: begin
            led_d = 1'b1;
            cnt_d = '0;
          end
          MODE_BLINK: begin
            if (tick) begin
              if (cnt_last) begin
                cnt_d = '0;
                led_d = !led_q;
              end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
              end
            end
          end
          MODE_ONESHOT: begin
            led_d = 1'b1;
            if (tick) begin
              if (cnt_last) begin
                cnt_d  = '0;
                led_d  = 1'b0;
                mode_d = MODE_OFF;
                done_d = 1'b1;
              end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
              end
            end
          end
          default: begin
            mode_d = MODE_OFF;
            led_d  = 1'b0;
            cnt_d  = '0;
          end
        endcase
      end
    end

    assign led_out[g] = led_q;
    assign done[g]    = done_q;
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Randomised bench for led_blink_ctrl against a tick-count arithmetic model.
module tb_led_blink_ctrl;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int PW = 8;
  localparam int DP = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          cfg_valid;
  logic [3:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_period;
  logic          cfg_ack;
  logic          cfg_err;
  logic [CH-1:0] led_out;
  logic [CH-1:0] done;
  logic [9:0]    obs;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Model: per channel the mode, period and the edge at which it was last configured.
  int m_mode[CH];
  int m_per[CH];
  int m_k[CH];
  bit ack_at[int];
  bit err_at[int];

  led_blink_ctrl #(
    .CH_NUM         (CH),
    .TICK_DIV       (TD),
    .PERIOD_W       (PW),
    .DEFAULT_PERIOD (DP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .led_out    (led_out),
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  assign obs = {led_out, done, cfg_ack, cfg_err};

  // Ticks are consumed at edges that are multiples of TD; the configuring edge itself is excluded.
  function automatic logic [9:0] exp_vec();
    logic [3:0] l;
    logic [3:0] d;
    logic       a;
    logic       e;
    int         t;
    l = '0;
    d = '0;
    for (int c = 0; c < CH; c++) begin
      t = edge_n / TD - m_k[c] / TD;
      case (m_mode[c])
        1: l[c] = 1'b1;
        2: l[c] = ((t / m_per[c]) % 2) == 1;
        3: begin
          l[c] = t < m_per[c];
          d[c] = (edge_n % TD == 0) && (t == m_per[c]);
        end
        default: l[c] = 1'b0;
      endcase
    end
    a = ack_at.exists(edge_n) ? 1'b1 : 1'b0;
    e = err_at.exists(edge_n) ? 1'b1 : 1'b0;
    return {l, d, a, e};
  endfunction

  task automatic reset_model();
    edge_n = 0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 2;
      m_per[c]  = DP;
      m_k[c]    = 0;
    end
    ack_at.delete();
    err_at.delete();
  endtask

  task automatic step();
    @(posedge sys_clk);
    edge_n++;
    #1;
  endtask

  task automatic wr(input int ch, input int mode, input int per);
    cfg_valid  = 1'b1;
    cfg_ch     = 4'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = PW'(per);
    step();
    if (ch < CH) begin
      m_mode[ch] = mode;
      m_per[ch]  = (per == 0) ? 1 : per;
      m_k[ch]    = edge_n;
      ack_at[edge_n + 1] = 1'b1;
    end else begin
      err_at[edge_n + 1] = 1'b1;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = '0;
    cfg_period = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_chk++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want %b", obs, 10'b0);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 40; i++) begin
      step();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_run edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
      if (edge_n == 11 || edge_n == 12 || edge_n == 24 || edge_n == 36) begin
        n_chk++;
        if (led_out !== ((edge_n == 12 || edge_n == 36) ? 4'hF : 4'h0)) begin
          n_fail++;
          $display("FAIL reset_phase edge %0d: got %b", edge_n, led_out);
        end
      end
    end
  endtask

  task automatic test_on_write();
    int acks;
    acks = 0;
    wr(1, 1, int'($urandom_range(0, 20)));
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL on_write edge %0d: got %b want %b", edge_n, obs, exp_vec());
    end
    for (int i = 0; i < 100; i++) begin
      step();
      acks += int'(cfg_ack);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL on_run edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
    end
    n_chk++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL on_ack_count: got %0d want 1", acks);
    end
  endtask

  task automatic test_oneshot();
    int n0;
    int fall;
    int dn;
    fall = -1;
    dn   = 0;
    while (edge_n % TD != 0) step();
    n0 = edge_n;
    wr(2, 3, 2);
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL oneshot_write edge %0d: got %b want %b", edge_n, obs, exp_vec());
    end
    for (int i = 0; i < 20; i++) begin
      step();
      dn += int'(done[2]);
      if (fall < 0 && !led_out[2]) fall = edge_n;
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL oneshot_run edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
    end
    n_chk++;
    if (dn !== 1 || fall !== n0 + 8) begin
      n_fail++;
      $display("FAIL oneshot_timing: done=%0d fall=%0d want done=1 fall=%0d", dn, fall, n0 + 8);
    end
  endtask

  task automatic test_reject();
    int errs;
    int acks;
    errs = 0;
    acks = 0;
    wr(int'($urandom_range(4, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reject_run edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
      errs += int'(cfg_err);
      acks += int'(cfg_ack);
      step();
    end
    n_chk++;
    if (errs !== 1 || acks !== 0) begin
      n_fail++;
      $display("FAIL reject_pulses: err=%0d ack=%0d want err=1 ack=0", errs, acks);
    end
  endtask

  task automatic test_tick_write();
    while (edge_n % TD != TD - 1) step();
    wr(0, 2, 5);
    for (int i = 0; i < 50; i++) begin
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL tick_write edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
      step();
    end
    wr(0, 2, 0);
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL period_zero edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        wr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      end else begin
        step();
      end
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    wr(3, 3, int'($urandom_range(4, 9)));
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_pre edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
    end
    sys_rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_async: got %b want %b", obs, 10'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      #1;
      n_chk++;
      if (obs !== 10'b0) begin
        n_fail++;
        $display("FAIL mid_hold: got %b want %b", obs, 10'b0);
      end
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 40; i++) begin
      step();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_restart edge %0d: got %b want %b", edge_n, obs, exp_vec());
      end
      if (edge_n == 12) begin
        n_chk++;
        if (led_out[3] !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_ch3_default: got %b want 1", led_out[3]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_on_write();
    test_oneshot();
    test_reject();
    test_tick_write();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
